// File: rtl/mcs4_pkg.sv
// mcs4: shared MCS-4 bus types (instruction phases, I/O-RAM opcodes, RAM addresses)
// used by the RAM bank and ROM-port blocks.
package mcs4;

    // Eight phases of one instruction cycle; X3 is the SYNC phase.
    typedef enum logic [2:0] {
        A1 = 3'd0,
        A2 = 3'd1,
        A3 = 3'd2,
        M1 = 3'd3,
        M2 = 3'd4,
        X1 = 3'd5,
        X2 = 3'd6,
        X3 = 3'd7
    } instr_cyc_t;

    // Second nibble (opa) of the I/O and RAM instruction group.
    typedef enum logic [3:0] {
        OPA_WRM    = 4'h0,
        OPA_WMP    = 4'h1,
        OPA_WRR    = 4'h2,
        OPA_UNUSED = 4'h3,
        OPA_WR0    = 4'h4,
        OPA_WR1    = 4'h5,
        OPA_WR2    = 4'h6,
        OPA_WR3    = 4'h7,
        OPA_SBM    = 4'h8,
        OPA_RDM    = 4'h9,
        OPA_RDR    = 4'hA,
        OPA_ADM    = 4'hB,
        OPA_RD0    = 4'hC,
        OPA_RD1    = 4'hD,
        OPA_RD2    = 4'hE,
        OPA_RD3    = 4'hF
    } ioram_opa_t;

    localparam logic [3:0] IORAM_GRP = 4'hE;

    typedef struct packed {
        logic [2:0] bank;
        logic [1:0] chip;
        logic [1:0] reg_sel;
        logic [3:0] char_sel;
    } ram_addr_t;

    localparam int Ram_ports_per_chip = 1;
    localparam int Ram_port_width     = 4;

    // Flat index of a character inside a chip/register/character array.
    function automatic int cell_index(int chip, int rsel, int idx, int regs_per_chip, int per_reg);
        return (chip * regs_per_chip + rsel) * per_reg + idx;
    endfunction

endpackage

// File: rtl/mcs4_cycle_tracker.sv
// mcs4_cycle_tracker: follows the A1..X3 instruction phases from SYNC and captures
// the opcode nibbles (opr in M1, opa in M2) seen on the data bus.
module mcs4_cycle_tracker
    import mcs4::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sync,
    input  logic [3:0] d_in,
    output instr_cyc_t phase,
    output logic [3:0] opr,
    output logic [3:0] opa
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= A1;
            opr   <= 4'h0;
            opa   <= 4'h0;
        end else begin
            // X3 + 1 wraps to A1; a SYNC seen in any phase realigns the count.
            if (sync) begin
                phase <= A1;
            end else begin
                phase <= instr_cyc_t'(phase + 3'd1);
            end
            if (phase == M1) begin
                opr <= d_in;
            end
            if (phase == M2) begin
                opa <= d_in;
            end
        end
    end

endmodule

// File: rtl/mcs4_ram_bank.sv
// mcs4_ram_bank: one MCS-4 RAM bank of NUM_CHIPS 4002-style chips on the 4-bit CPU bus.
// Defining MCS4_RAM_BANK_DEBUG_EN adds a registered side-band read port (dbg_*).
module mcs4_ram_bank
    import mcs4::*;
#(
    parameter int NUM_CHIPS      = 4,
    parameter int REGS_PER_CHIP  = 4,
    parameter int CHARS_PER_REG  = 16,
    parameter int STATUS_PER_REG = 4,
    parameter int PORT_WIDTH     = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            sync,
    input  logic                            cm_ram,
    input  logic [3:0]                      d_in,
    output logic [3:0]                      d_out,
    output logic                            d_oe,
    output logic [NUM_CHIPS*PORT_WIDTH-1:0] port_out
`ifdef MCS4_RAM_BANK_DEBUG_EN
    ,
    input  ram_addr_t                       dbg_addr,
    input  logic                            dbg_stat,
    input  logic [1:0]                      dbg_schar,
    output logic [3:0]                      dbg_data
`endif
);

    localparam int MAIN_DEPTH = NUM_CHIPS * REGS_PER_CHIP * CHARS_PER_REG;
    localparam int STAT_DEPTH = NUM_CHIPS * REGS_PER_CHIP * STATUS_PER_REG;
    localparam int MAIN_AW    = (MAIN_DEPTH > 1) ? $clog2(MAIN_DEPTH) : 1;
    localparam int STAT_AW    = (STAT_DEPTH > 1) ? $clog2(STAT_DEPTH) : 1;

    instr_cyc_t   phase;
    logic [3:0]   opr;
    logic [3:0]   opa;

    logic [3:0]   main_mem [MAIN_DEPTH];
    logic [3:0]   stat_mem [STAT_DEPTH];

    logic         io_act;
    logic         src_pend;
    logic [1:0]   src_chip;
    logic [1:0]   src_reg;
    logic [1:0]   sel_chip;
    logic [1:0]   sel_reg;
    logic [3:0]   sel_char;
    logic         sel_valid;

    logic [1:0]         status_n;
    logic               status_ok;
    logic               exec;
    logic               wr_main;
    logic               wr_port;
    logic               wr_stat;
    logic               rd_main;
    logic               rd_stat;
    logic [MAIN_AW-1:0] main_idx;
    logic [STAT_AW-1:0] stat_idx;

    mcs4_cycle_tracker u_tracker (
        .clk   (clk),
        .rst_n (rst_n),
        .sync  (sync),
        .d_in  (d_in),
        .phase (phase),
        .opr   (opr),
        .opa   (opa)
    );

    always_comb begin
        status_n  = opa[1:0];
        main_idx  = MAIN_AW'(cell_index(int'(sel_chip), int'(sel_reg), int'(sel_char),
                                        REGS_PER_CHIP, CHARS_PER_REG));
        stat_idx  = STAT_AW'(cell_index(int'(sel_chip), int'(sel_reg), int'(status_n),
                                        REGS_PER_CHIP, STATUS_PER_REG));
        status_ok = int'(status_n) < STATUS_PER_REG;
        // A SYNC landing in X2 is a resync, so the pending operation is dropped.
        exec      = (phase == X2) && io_act && sel_valid && !sync;
        wr_main   = exec && (opa == OPA_WRM);
        wr_port   = exec && (opa == OPA_WMP);
        wr_stat   = exec && (opa[3:2] == 2'b01) && status_ok;
        rd_main   = exec && ((opa == OPA_SBM) || (opa == OPA_RDM) || (opa == OPA_ADM));
        rd_stat   = exec && (opa[3:2] == 2'b11) && status_ok;
    end

    // Instruction decode and SRC address capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io_act    <= 1'b0;
            src_pend  <= 1'b0;
            src_chip  <= 2'b00;
            src_reg   <= 2'b00;
            sel_chip  <= 2'b00;
            sel_reg   <= 2'b00;
            sel_char  <= 4'h0;
            sel_valid <= 1'b0;
        end else begin
            if (sync || phase == X3) begin
                io_act <= 1'b0;
            end else if (phase == M2) begin
                io_act <= cm_ram && (opr == IORAM_GRP);
            end

            src_pend <= 1'b0;
            if (phase == X2 && cm_ram && !io_act && !sync) begin
                src_pend <= 1'b1;
                src_chip <= d_in[3:2];
                src_reg  <= d_in[1:0];
            end

            // The selection only changes once the character nibble has arrived.
            if (phase == X3 && src_pend) begin
                sel_chip  <= src_chip;
                sel_reg   <= src_reg;
                sel_char  <= d_in;
                sel_valid <= (int'(src_chip) < NUM_CHIPS) &&
                             (int'(src_reg) < REGS_PER_CHIP) &&
                             (int'(d_in) < CHARS_PER_REG);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAIN_DEPTH; i++) begin
                main_mem[i] <= 4'h0;
            end
            for (int i = 0; i < STAT_DEPTH; i++) begin
                stat_mem[i] <= 4'h0;
            end
        end else begin
            if (wr_main) begin
                main_mem[main_idx] <= d_in;
            end
            if (wr_stat) begin
                stat_mem[stat_idx] <= d_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            port_out <= '0;
        end else begin
            for (int c = 0; c < NUM_CHIPS; c++) begin
                if (wr_port && int'(sel_chip) == c) begin
                    port_out[c*PORT_WIDTH +: PORT_WIDTH] <= d_in[PORT_WIDTH-1:0];
                end
            end
        end
    end

    // Read data is registered at the X2 edge so it sits on the bus for X3 only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_out <= 4'h0;
            d_oe  <= 1'b0;
        end else begin
            d_out <= 4'h0;
            d_oe  <= 1'b0;
            if (rd_main) begin
                d_out <= main_mem[main_idx];
                d_oe  <= 1'b1;
            end else if (rd_stat) begin
                d_out <= stat_mem[stat_idx];
                d_oe  <= 1'b1;
            end
        end
    end

`ifdef MCS4_RAM_BANK_DEBUG_EN
    logic               dbg_ok;
    logic [MAIN_AW-1:0] dbg_main_idx;
    logic [STAT_AW-1:0] dbg_stat_idx;

    always_comb begin
        dbg_ok       = (int'(dbg_addr.chip) < NUM_CHIPS) &&
                       (int'(dbg_addr.reg_sel) < REGS_PER_CHIP) &&
                       (dbg_stat ? (int'(dbg_schar) < STATUS_PER_REG)
                                 : (int'(dbg_addr.char_sel) < CHARS_PER_REG));
        dbg_main_idx = MAIN_AW'(cell_index(int'(dbg_addr.chip), int'(dbg_addr.reg_sel),
                                           int'(dbg_addr.char_sel), REGS_PER_CHIP, CHARS_PER_REG));
        dbg_stat_idx = STAT_AW'(cell_index(int'(dbg_addr.chip), int'(dbg_addr.reg_sel),
                                           int'(dbg_schar), REGS_PER_CHIP, STATUS_PER_REG));
    end

    // Samples the arrays before this edge's write lands, so a colliding write is not seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_data <= 4'h0;
        end else if (!dbg_ok) begin
            dbg_data <= 4'h0;
        end else if (dbg_stat) begin
            dbg_data <= stat_mem[dbg_stat_idx];
        end else begin
            dbg_data <= main_mem[dbg_main_idx];
        end
    end
`endif

endmodule

// File: tb/tb_mcs4_ram_bank.sv
// tb_mcs4_ram_bank: drives two RAM banks (full-size and a reduced geometry) with whole
// instruction cycles and compares bus reads and output ports with an array-based model.
module tb_mcs4_ram_bank;

    localparam logic [3:0] IORAM_OPR = 4'hE;
    localparam logic [3:0] SRC_OPR   = 4'h2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sync;
    logic       cm_ram;
    logic [3:0] d_in;
    logic [3:0] d_out_a;
    logic [3:0] d_out_b;
    logic       d_oe_a;
    logic       d_oe_b;
    logic [15:0] port_a;
    logic [5:0]  port_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mcs4_ram_bank u_dut_a (
        .clk(clk), .rst_n(rst_n), .sync(sync), .cm_ram(cm_ram), .d_in(d_in),
        .d_out(d_out_a), .d_oe(d_oe_a), .port_out(port_a)
    );

    mcs4_ram_bank #(
        .NUM_CHIPS(2), .REGS_PER_CHIP(3), .CHARS_PER_REG(12), .STATUS_PER_REG(3), .PORT_WIDTH(3)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .sync(sync), .cm_ram(cm_ram), .d_in(d_in),
        .d_out(d_out_b), .d_oe(d_oe_b), .port_out(port_b)
    );

    // ---------------- reference model: plain arrays per instance ----------------
    int lim_chips [2] = '{4, 2};
    int lim_regs  [2] = '{4, 3};
    int lim_chars [2] = '{16, 12};
    int lim_stat  [2] = '{4, 3};
    int lim_pw    [2] = '{4, 3};

    logic [3:0] m_main [2][4][4][16];
    logic [3:0] m_stat [2][4][4][4];
    logic [3:0] m_port [2][4];
    int  s_chip;
    int  s_reg;
    int  s_char;
    bit  s_have;

    logic [9:0] exp_q[$];
    bit         last_oe_a;
    bit         last_oe_b;
    logic [3:0] last_out_a;
    logic [3:0] last_out_b;

    function automatic void model_reset();
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < 4; c++) begin
                m_port[k][c] = 4'h0;
                for (int r = 0; r < 4; r++) begin
                    for (int ch = 0; ch < 16; ch++) m_main[k][c][r][ch] = 4'h0;
                    for (int s = 0; s < 4; s++) m_stat[k][c][r][s] = 4'h0;
                end
            end
        s_have = 1'b0;
        s_chip = 0;
        s_reg  = 0;
        s_char = 0;
    endfunction

    function automatic bit sel_ok(int k);
        return s_have && s_chip < lim_chips[k] && s_reg < lim_regs[k] && s_char < lim_chars[k];
    endfunction

    function automatic void model_read(input int k, input logic [3:0] opa,
                                       output bit oe, output logic [3:0] v);
        int n;
        oe = 1'b0;
        v  = 4'h0;
        n  = int'(opa) - 12;
        if (sel_ok(k)) begin
            if (opa == 4'h8 || opa == 4'h9 || opa == 4'hB) begin
                oe = 1'b1;
                v  = m_main[k][s_chip][s_reg][s_char];
            end else if (opa >= 4'hC && n < lim_stat[k]) begin
                oe = 1'b1;
                v  = m_stat[k][s_chip][s_reg][n];
            end
        end
    endfunction

    function automatic void model_write(int k, logic [3:0] opa, logic [3:0] d);
        int n;
        n = int'(opa) - 4;
        if (sel_ok(k)) begin
            if (opa == 4'h0) m_main[k][s_chip][s_reg][s_char] = d;
            else if (opa == 4'h1) m_port[k][s_chip] = d & 4'((1 << lim_pw[k]) - 1);
            else if (opa >= 4'h4 && opa <= 4'h7 && n < lim_stat[k]) m_stat[k][s_chip][s_reg][n] = d;
        end
    endfunction

    function automatic logic [15:0] exp_port(int k);
        logic [15:0] v;
        v = 16'h0;
        for (int c = 0; c < lim_chips[k]; c++) v = v | (16'(m_port[k][c]) << (c * lim_pw[k]));
        return v;
    endfunction

    // ---------------- checking and driving ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic step(input bit s, input bit cm, input logic [3:0] d);
        sync   = s;
        cm_ram = cm;
        d_in   = d;
        @(posedge clk);
        #1;
    endtask

    // One instruction from A1; sync_at < 7 cuts it short with a SYNC in that phase.
    task automatic run_instr(input logic [3:0] opr, input logic [3:0] opa, input bit cm_m2,
                             input bit cm_x2, input logic [3:0] dx2, input logic [3:0] dx3,
                             input int sync_at);
        bit         full;
        bit         io_instr;
        bit         stray_oe;
        bit         oe_k;
        logic [3:0] out_k;
        logic [9:0] exp_v;
        logic [9:0] got_v;
        bit         cm_p;
        logic [3:0] d_p;
        full     = (sync_at == 7);
        io_instr = cm_m2 && (opr == IORAM_OPR);
        stray_oe = 1'b0;
        got_v    = '0;
        if (full) begin
            exp_v = '0;
            if (io_instr) begin
                for (int k = 0; k < 2; k++) begin
                    model_read(k, opa, oe_k, out_k);
                    exp_v[k*5 +: 5] = {oe_k, out_k};
                end
            end
            exp_q.push_back(exp_v);
        end
        for (int p = 0; p <= sync_at; p++) begin
            cm_p = (p == 4) ? cm_m2 : ((p == 6) ? cm_x2 : 1'b0);
            case (p)
                3:       d_p = opr;
                4:       d_p = opa;
                6:       d_p = dx2;
                7:       d_p = dx3;
                default: d_p = 4'($urandom_range(0, 15));
            endcase
            step(p == sync_at, cm_p, d_p);
            if (p == 6 && full) begin
                got_v      = {d_oe_b, d_out_b, d_oe_a, d_out_a};
                last_oe_a  = d_oe_a;
                last_out_a = d_out_a;
                last_oe_b  = d_oe_b;
                last_out_b = d_out_b;
            end else if (d_oe_a || d_oe_b) begin
                stray_oe = 1'b1;
            end
        end
        check("d_oe_outside_x3", 32'(stray_oe), 32'd0);
        if (full) begin
            exp_v = exp_q.pop_front();
            check("rd_oe_a", 32'(got_v[4]), 32'(exp_v[4]));
            check("rd_out_a", 32'(got_v[3:0]), 32'(exp_v[3:0]));
            check("rd_oe_b", 32'(got_v[9]), 32'(exp_v[9]));
            check("rd_out_b", 32'(got_v[8:5]), 32'(exp_v[8:5]));
            if (io_instr) begin
                model_write(0, opa, dx2);
                model_write(1, opa, dx2);
            end else if (cm_x2) begin
                s_chip = int'(dx2[3:2]);
                s_reg  = int'(dx2[1:0]);
                s_char = int'(dx3);
                s_have = 1'b1;
            end
        end
        check("port_out_a", 32'(port_a), 32'(exp_port(0)));
        check("port_out_b", 32'(port_b), 32'(exp_port(1)));
    endtask

    task automatic src(input logic [3:0] pair, input logic [3:0] chr);
        run_instr(SRC_OPR, 4'h1, 1'b0, 1'b1, pair, chr, 7);
    endtask

    task automatic io(input logic [3:0] opa, input logic [3:0] data);
        run_instr(IORAM_OPR, opa, 1'b1, 1'b0, data, 4'h0, 7);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [3:0]  opr;
        logic [3:0]  opa;
        bit          cm_m2;
        bit          cm_x2;
        logic [3:0]  dx2;
        logic [3:0]  dx3;
        bit          oe_a;
        logic [3:0]  out_a;
        bit          oe_b;
        logic [3:0]  out_b;
        logic [15:0] pa;
        logic [5:0]  pb;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic [3:0] opr, logic [3:0] opa, bit cm_m2, bit cm_x2,
                                logic [3:0] dx2, logic [3:0] dx3, bit oe_a, logic [3:0] out_a,
                                bit oe_b, logic [3:0] out_b, logic [15:0] pa, logic [5:0] pb);
        vec_t v;
        v.opr = opr; v.opa = opa; v.cm_m2 = cm_m2; v.cm_x2 = cm_x2; v.dx2 = dx2; v.dx3 = dx3;
        v.oe_a = oe_a; v.out_a = out_a; v.oe_b = oe_b; v.out_b = out_b; v.pa = pa; v.pb = pb;
        vecs.push_back(v);
    endfunction

    initial begin
        vec_t v;
        model_reset();
        // SRC rows use opr 2/cm_x2; I/O rows use opr E/cm_m2.
        add(4'h2, 4'h1, 0, 1, 4'h9, 4'h5, 0, 4'h0, 0, 4'h0, 16'h0000, 6'h00); // chip2 reg1 char5
        add(4'hE, 4'h0, 1, 0, 4'hA, 4'h0, 0, 4'h0, 0, 4'h0, 16'h0000, 6'h00); // WRM A
        add(4'h2, 4'h1, 0, 1, 4'h9, 4'h5, 0, 4'h0, 0, 4'h0, 16'h0000, 6'h00);
        add(4'hE, 4'h9, 1, 0, 4'h0, 4'h0, 1, 4'hA, 0, 4'h0, 16'h0000, 6'h00); // RDM
        add(4'h2, 4'h1, 0, 1, 4'hC, 4'h0, 0, 4'h0, 0, 4'h0, 16'h0000, 6'h00); // chip3
        add(4'hE, 4'h1, 1, 0, 4'h6, 4'h0, 0, 4'h0, 0, 4'h0, 16'h6000, 6'h00); // WMP 6
        add(4'h2, 4'h1, 0, 1, 4'h9, 4'h5, 0, 4'h0, 0, 4'h0, 16'h6000, 6'h00);
        add(4'hE, 4'h6, 1, 0, 4'hC, 4'h0, 0, 4'h0, 0, 4'h0, 16'h6000, 6'h00); // WR2 C
        add(4'hE, 4'hE, 1, 0, 4'h0, 4'h0, 1, 4'hC, 0, 4'h0, 16'h6000, 6'h00); // RD2
        add(4'hE, 4'hD, 1, 0, 4'h0, 4'h0, 1, 4'h0, 0, 4'h0, 16'h6000, 6'h00); // RD1
        add(4'hE, 4'h0, 0, 0, 4'h3, 4'h0, 0, 4'h0, 0, 4'h0, 16'h6000, 6'h00); // WRM, cm_ram low
        add(4'hE, 4'h9, 1, 0, 4'h0, 4'h0, 1, 4'hA, 0, 4'h0, 16'h6000, 6'h00);
        add(4'hE, 4'h8, 1, 0, 4'h0, 4'h0, 1, 4'hA, 0, 4'h0, 16'h6000, 6'h00); // SBM
        add(4'hE, 4'hB, 1, 0, 4'h0, 4'h0, 1, 4'hA, 0, 4'h0, 16'h6000, 6'h00); // ADM
        add(4'hE, 4'h2, 1, 0, 4'hF, 4'h0, 0, 4'h0, 0, 4'h0, 16'h6000, 6'h00); // WRR
        add(4'hE, 4'h3, 1, 0, 4'hF, 4'h0, 0, 4'h0, 0, 4'h0, 16'h6000, 6'h00); // opa 3
        add(4'hE, 4'hA, 1, 0, 4'h0, 4'h0, 0, 4'h0, 0, 4'h0, 16'h6000, 6'h00); // RDR
        add(4'hE, 4'h9, 1, 0, 4'h0, 4'h0, 1, 4'hA, 0, 4'h0, 16'h6000, 6'h00);
        add(4'h2, 4'h1, 0, 1, 4'h5, 4'h3, 0, 4'h0, 0, 4'h0, 16'h6000, 6'h00); // chip1 reg1 char3
        add(4'hE, 4'h0, 1, 0, 4'h7, 4'h0, 0, 4'h0, 0, 4'h0, 16'h6000, 6'h00);
        add(4'hE, 4'h9, 1, 0, 4'h0, 4'h0, 1, 4'h7, 1, 4'h7, 16'h6000, 6'h00);
        add(4'hE, 4'h7, 1, 0, 4'h9, 4'h0, 0, 4'h0, 0, 4'h0, 16'h6000, 6'h00); // WR3 9
        add(4'hE, 4'hF, 1, 0, 4'h0, 4'h0, 1, 4'h9, 0, 4'h0, 16'h6000, 6'h00); // RD3
        add(4'hE, 4'hE, 1, 0, 4'h0, 4'h0, 1, 4'h0, 1, 4'h0, 16'h6000, 6'h00); // RD2
        add(4'hE, 4'h1, 1, 0, 4'h5, 4'h0, 0, 4'h0, 0, 4'h0, 16'h6050, 6'h28); // WMP 5 chip1
        add(4'h2, 4'h1, 0, 1, 4'h4, 4'hC, 0, 4'h0, 0, 4'h0, 16'h6050, 6'h28); // char 12
        add(4'hE, 4'h0, 1, 0, 4'hE, 4'h0, 0, 4'h0, 0, 4'h0, 16'h6050, 6'h28);
        add(4'hE, 4'h9, 1, 0, 4'h0, 4'h0, 1, 4'hE, 0, 4'h0, 16'h6050, 6'h28);
        add(4'h2, 4'h1, 0, 1, 4'h7, 4'h0, 0, 4'h0, 0, 4'h0, 16'h6050, 6'h28); // reg 3
        add(4'hE, 4'h9, 1, 0, 4'h0, 4'h0, 1, 4'h0, 0, 4'h0, 16'h6050, 6'h28);
        add(4'h2, 4'h1, 0, 1, 4'h5, 4'h3, 0, 4'h0, 0, 4'h0, 16'h6050, 6'h28);
        add(4'hE, 4'h9, 1, 0, 4'h0, 4'h0, 1, 4'h7, 1, 4'h7, 16'h6050, 6'h28);

        // ---------------- reset ----------------
        rst_n = 1'b0; sync = 1'b0; cm_ram = 1'b0; d_in = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_d_oe_a", 32'(d_oe_a), 32'd0);
        check("reset_d_out_a", 32'(d_out_a), 32'd0);
        check("reset_port_a", 32'(port_a), 32'd0);
        check("reset_port_b", 32'(port_b), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            run_instr(v.opr, v.opa, v.cm_m2, v.cm_x2, v.dx2, v.dx3, 7);
            check($sformatf("vec%0d_oe_a", i), 32'(last_oe_a), 32'(v.oe_a));
            check($sformatf("vec%0d_out_a", i), 32'(last_out_a), 32'(v.out_a));
            check($sformatf("vec%0d_oe_b", i), 32'(last_oe_b), 32'(v.oe_b));
            check($sformatf("vec%0d_out_b", i), 32'(last_out_b), 32'(v.out_b));
            check($sformatf("vec%0d_port_a", i), 32'(port_a), 32'(v.pa));
            check($sformatf("vec%0d_port_b", i), 32'(port_b), 32'(v.pb));
        end

        // ---------------- resync mid-write ----------------
        src(4'h9, 4'h5);
        run_instr(IORAM_OPR, 4'h0, 1'b1, 1'b0, 4'h1, 4'h0, 3);   // SYNC in M1
        io(4'h9, 4'h0);
        check("sync_m1_no_write", 32'(last_out_a), 32'hA);
        check("sync_m1_realigned", 32'(last_oe_a), 32'd1);
        run_instr(IORAM_OPR, 4'h0, 1'b1, 1'b0, 4'h2, 4'h0, 5);   // SYNC in X1
        io(4'h9, 4'h0);
        check("sync_x1_no_write", 32'(last_out_a), 32'hA);

        // ---------------- reset during X2 of a WRM ----------------
        for (int p = 0; p < 6; p++)
            step(1'b0, p == 4, (p == 3) ? IORAM_OPR : ((p == 4) ? 4'h0 : 4'h5));
        sync = 1'b0; cm_ram = 1'b0; d_in = 4'h5;
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_d_oe_a", 32'(d_oe_a), 32'd0);
        check("midreset_d_out_a", 32'(d_out_a), 32'd0);
        check("midreset_port_a", 32'(port_a), 32'd0);
        check("midreset_port_b", 32'(port_b), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        io(4'h9, 4'h0);
        check("midreset_sel_cleared", 32'(last_oe_a), 32'd0);
        src(4'h9, 4'h5);
        io(4'h9, 4'h0);
        check("midreset_mem_oe", 32'(last_oe_a), 32'd1);
        check("midreset_mem_zero", 32'(last_out_a), 32'd0);

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 300; i++) begin
            int kind;
            int sync_at;
            kind    = int'($urandom_range(0, 9));
            sync_at = ($urandom_range(0, 15) == 0) ? (($urandom_range(0, 1) == 0) ? 3 : 5) : 7;
            if (kind < 4)
                run_instr(SRC_OPR, 4'($urandom_range(0, 7) * 2 + 1), 1'b0, 1'b1,
                          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), sync_at);
            else if (kind < 9)
                run_instr(IORAM_OPR, 4'($urandom_range(0, 15)), $urandom_range(0, 7) != 0, 1'b0,
                          4'($urandom_range(0, 15)), 4'h0, sync_at);
            else
                run_instr(4'($urandom_range(0, 13)), 4'($urandom_range(0, 15)),
                          $urandom_range(0, 1) == 1, 1'b0, 4'($urandom_range(0, 15)), 4'h0, sync_at);
        end

        // ---------------- sweep memory contents ----------------
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                for (int ch = 0; ch < 16; ch++) begin
                    src(4'((c << 2) | r), 4'(ch));
                    io(4'h9, 4'h0);
                end
                src(4'((c << 2) | r), 4'h0);
                for (int s = 0; s < 4; s++) io(4'(12 + s), 4'h0);
            end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
